// File: rtl/minisrc_pkg.sv
// Shared definitions for the Mini SRC control unit: opcodes, IR field
// positions, sequencer states and opcode-class helpers.
package minisrc_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int OPC_LSB = 27;
  localparam int RA_LSB  = 23;
  localparam int RB_LSB  = 19;
  localparam int RC_LSB  = 15;

  typedef enum logic [2:0] {
    S_RESET,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_HALT
  } state_t;

  function automatic logic [4:0] opcode_of(input logic [31:0] ir);
    return ir[OPC_LSB +: 5];
  endfunction

  function automatic logic [3:0] field_of(input logic [31:0] ir, input int lsb);
    return ir[lsb +: 4];
  endfunction

  // Three-register ALU operations: Rb latched into Y, Rc on the bus.
  function automatic logic is_alu3(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  function automatic logic is_alu2(input logic [4:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/reg_select.sv
// Turns a 4-bit register field into a one-hot register strobe vector,
// gated by an enable so the vector is all-zero when the slot is unused.
module reg_select #(
  parameter int NUM_REGS = 16
) (
  input  logic [3:0]          field,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en && (32'(field) < NUM_REGS)) onehot[field] = 1'b1;
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for Mini SRC: fetch (T0-T2) then a per-class
// execute sequence (T3-T5), with HALT as a sink left only through clr.
module control_unit
  import minisrc_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [31:0]         IR_Data,
  input  logic                mem_rdy,
  output logic                PC_out,
  output logic                PC_in,
  output logic                MAR_in,
  output logic                Read,
  output logic                MDR_in,
  output logic                MDR_out,
  output logic                IR_in,
  output logic                Y_in,
  output logic                Z_in,
  output logic                Zlow_out,
  output logic                inc_pc,
  output logic [4:0]          alu_instruction,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic                run,
  output logic                illegal,
  output state_t              state_dbg
);

  state_t     state_q, state_d;
  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic [3:0] out_field;
  logic       alu3, alu2;
  logic       in_en, out_en;
  logic       unused_ir_bits;

  // IR is only meaningful in T3-T5; it was loaded at the end of T2.
  assign opcode         = opcode_of(IR_Data);
  assign ra             = field_of(IR_Data, RA_LSB);
  assign rb             = field_of(IR_Data, RB_LSB);
  assign rc             = field_of(IR_Data, RC_LSB);
  assign alu3           = is_alu3(opcode);
  assign alu2           = is_alu2(opcode);
  assign unused_ir_bits = ^IR_Data[14:0];
  assign state_dbg      = state_q;

  always_ff @(posedge clk) begin
    if (clr) state_q <= S_RESET;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    PC_out          = 1'b0;
    PC_in           = 1'b0;
    MAR_in          = 1'b0;
    Read            = 1'b0;
    MDR_in          = 1'b0;
    MDR_out         = 1'b0;
    IR_in           = 1'b0;
    Y_in            = 1'b0;
    Z_in            = 1'b0;
    Zlow_out        = 1'b0;
    inc_pc          = 1'b0;
    alu_instruction = 5'b00000;
    run             = 1'b0;
    illegal         = 1'b0;
    in_en           = 1'b0;
    out_en          = 1'b0;
    out_field       = rb;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0: begin
        run     = 1'b1;
        PC_out  = 1'b1;
        MAR_in  = 1'b1;
        inc_pc  = 1'b1;
        Z_in    = 1'b1;
        state_d = S_T1;
      end
      // Z holds PC+1 from T0; it is written back only once the read lands.
      S_T1: begin
        run    = 1'b1;
        Read   = 1'b1;
        MDR_in = 1'b1;
        if (mem_rdy) begin
          Zlow_out = 1'b1;
          PC_in    = 1'b1;
          state_d  = S_T2;
        end
      end
      S_T2: begin
        run     = 1'b1;
        MDR_out = 1'b1;
        IR_in   = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        run = 1'b1;
        if (alu3) begin
          out_en  = 1'b1;
          Y_in    = 1'b1;
          state_d = S_T4;
        end else if (alu2) begin
          out_en          = 1'b1;
          alu_instruction = opcode;
          Z_in            = 1'b1;
          state_d         = S_T4;
        end else if (opcode == OP_NOP) begin
          state_d = S_T0;
        end else if (opcode == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          illegal = 1'b1;
          state_d = S_T0;
        end
      end
      S_T4: begin
        run     = 1'b1;
        state_d = S_T0;
        if (alu3) begin
          out_en          = 1'b1;
          out_field       = rc;
          alu_instruction = opcode;
          Z_in            = 1'b1;
          state_d         = S_T5;
        end else if (alu2) begin
          Zlow_out = 1'b1;
          in_en    = 1'b1;
        end
      end
      S_T5: begin
        run      = 1'b1;
        Zlow_out = 1'b1;
        in_en    = 1'b1;
        state_d  = S_T0;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  reg_select #(.NUM_REGS(NUM_REGS)) u_sel_in (
    .field  (ra),
    .en     (in_en),
    .onehot (reg_in)
  );

  reg_select #(.NUM_REGS(NUM_REGS)) u_sel_out (
    .field  (out_field),
    .en     (out_en),
    .onehot (reg_out)
  );

endmodule
